pipe_hazard_ctrl: RTL and testbench

//  Sequences the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC of the 5-stage core.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Holds the FSM state encoding and the pipeline-register slot indices.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  localparam int unsigned SLOT_IFID  = 0;
  localparam int unsigned SLOT_IDEX  = 1;
  localparam int unsigned SLOT_EXMEM = 2;
  localparam int unsigned SLOT_MEMWB = 3;
  localparam int unsigned NUM_SLOTS  = 4;

  localparam int unsigned MC_CNT_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter for performance monitoring.
// Holds at all-ones instead of wrapping; cleared by asynchronous active-low reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencing: load-use stalls, taken-branch squash and
// multi-cycle EX holds, with Mealy write/flush controls and perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             mc_start_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_flush_o,
  output logic             exmem_write_o,
  output logic             exmem_flush_o,
  output logic             memwb_write_o,
  output logic             memwb_flush_o,
  output logic             mc_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_t                state_q, state_d;
  logic [MC_CNT_W-1:0]   mc_cnt_q, mc_cnt_d;
  logic [NUM_SLOTS-1:0]  reg_write, reg_flush;
  logic                  pc_write;
  logic                  flush_evt;
  logic                  load_use;

  assign load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mc_cnt_d  = mc_cnt_q;
    pc_write  = 1'b1;
    reg_write = '1;
    reg_flush = '0;
    flush_evt = 1'b0;

    if (!rst_i) begin
      pc_write  = 1'b0;
      reg_write = '0;
      reg_flush = '1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch_taken_i) begin
            reg_flush[SLOT_IFID]  = 1'b1;
            reg_flush[SLOT_IDEX]  = 1'b1;
            reg_flush[SLOT_EXMEM] = 1'b1;
            flush_evt             = 1'b1;
          end else if (mc_start_i && (MC_LAT > 1)) begin
            pc_write              = 1'b0;
            reg_write[SLOT_IFID]  = 1'b0;
            reg_write[SLOT_IDEX]  = 1'b0;
            reg_flush[SLOT_EXMEM] = 1'b1;
            mc_cnt_d              = MC_CNT_W'(MC_LAT - 1);
            state_d               = MC_BUSY;
          end else if (load_use) begin
            pc_write             = 1'b0;
            reg_write[SLOT_IFID] = 1'b0;
            reg_flush[SLOT_IDEX] = 1'b1;
          end
        end
        MC_BUSY: begin
          // Final count is the release cycle: EX result moves on, no stall.
          if (mc_cnt_q > MC_CNT_W'(1)) begin
            pc_write              = 1'b0;
            reg_write[SLOT_IFID]  = 1'b0;
            reg_write[SLOT_IDEX]  = 1'b0;
            reg_flush[SLOT_EXMEM] = 1'b1;
            mc_cnt_d              = mc_cnt_q - 1'b1;
          end else begin
            mc_cnt_d = '0;
            state_d  = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign pc_write_o    = pc_write;
  assign ifid_write_o  = reg_write[SLOT_IFID];
  assign ifid_flush_o  = reg_flush[SLOT_IFID];
  assign idex_write_o  = reg_write[SLOT_IDEX];
  assign idex_flush_o  = reg_flush[SLOT_IDEX];
  assign exmem_write_o = reg_write[SLOT_EXMEM];
  assign exmem_flush_o = reg_flush[SLOT_EXMEM];
  assign memwb_write_o = reg_write[SLOT_MEMWB];
  assign memwb_flush_o = reg_flush[SLOT_MEMWB];
  assign mc_busy_o     = (state_q == MC_BUSY);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (!pc_write),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_evt),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MC_LAT=4 and 4-bit counters.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MC_LAT = 4;
  localparam int unsigned CNT_W  = 4;

  // Control vector order: {pc, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_w, memwb_f}
  localparam logic [8:0] CTL_RST  = 9'b0_01_01_01_01;
  localparam logic [8:0] CTL_RUN  = 9'b1_10_10_10_10;
  localparam logic [8:0] CTL_LU   = 9'b0_00_11_10_10;
  localparam logic [8:0] CTL_BR   = 9'b1_11_11_11_10;
  localparam logic [8:0] CTL_MC   = 9'b0_00_00_11_10;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [4:0]       ifid_rs_i, ifid_rt_i, idex_rt_i;
  logic             idex_memread_i, mc_start_i, branch_taken_i;
  logic             pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o;
  logic             exmem_write_o, exmem_flush_o, memwb_write_o, memwb_flush_o, mc_busy_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .mc_start_i     (mc_start_i),
    .branch_taken_i (branch_taken_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_write_o   (idex_write_o),
    .idex_flush_o   (idex_flush_o),
    .exmem_write_o  (exmem_write_o),
    .exmem_flush_o  (exmem_flush_o),
    .memwb_write_o  (memwb_write_o),
    .memwb_flush_o  (memwb_flush_o),
    .mc_busy_o      (mc_busy_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  function automatic logic [8:0] ctl();
    return {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o,
            exmem_write_o, exmem_flush_o, memwb_write_o, memwb_flush_o};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifid_rs_i = 5'd0; ifid_rt_i = 5'd0; idex_rt_i = 5'd0;
    idex_memread_i = 1'b0; mc_start_i = 1'b0; branch_taken_i = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt);
    idex_memread_i = 1'b1; ifid_rs_i = rs; ifid_rt_i = rt; idex_rt_i = ex_rt;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    repeat (3) tick();
    check_eq("rst_ctl", 32'(ctl()), 32'(CTL_RST));
    check_eq("rst_busy", 32'(mc_busy_o), 32'd0);
    check_eq("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    check_eq("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
    rst_i = 1'b1;
    #1;
    check_eq("post_rst_ctl", 32'(ctl()), 32'(CTL_RUN));
  endtask

  initial begin
    idle_inputs();
    do_reset();
    tick();
    check_eq("no_stall_after_rst", 32'(stall_cnt_o), 32'd0);

    // Load-use on rt match, then rs match
    set_load_use(5'd3, 5'd8, 5'd8);
    #1 check_eq("lu_rt_ctl", 32'(ctl()), 32'(CTL_LU));
    tick();
    check_eq("lu_rt_stall_cnt", 32'(stall_cnt_o), 32'd1);
    set_load_use(5'd9, 5'd4, 5'd9);
    #1 check_eq("lu_rs_ctl", 32'(ctl()), 32'(CTL_LU));
    tick();
    check_eq("lu_rs_stall_cnt", 32'(stall_cnt_o), 32'd2);
    // $zero destination never stalls, nor does a non-load
    set_load_use(5'd0, 5'd0, 5'd0);
    #1 check_eq("lu_r0_ctl", 32'(ctl()), 32'(CTL_RUN));
    tick();
    set_load_use(5'd8, 5'd8, 5'd8);
    idex_memread_i = 1'b0;
    #1 check_eq("no_load_ctl", 32'(ctl()), 32'(CTL_RUN));
    tick();
    check_eq("lu_r0_stall_cnt", 32'(stall_cnt_o), 32'd2);
    idle_inputs();

    // Taken branch
    branch_taken_i = 1'b1;
    #1 check_eq("br_ctl", 32'(ctl()), 32'(CTL_BR));
    tick();
    branch_taken_i = 1'b0;
    check_eq("br_flush_cnt", 32'(flush_cnt_o), 32'd1);
    check_eq("br_stall_cnt", 32'(stall_cnt_o), 32'd2);
    #1 check_eq("br_after_ctl", 32'(ctl()), 32'(CTL_RUN));

    // Mid-run reset
    do_reset();

    // Multi-cycle op: 3 stall cycles, release on the 4th
    mc_start_i = 1'b1;
    #1 check_eq("mc_c1_ctl", 32'(ctl()), 32'(CTL_MC));
    check_eq("mc_c1_busy", 32'(mc_busy_o), 32'd0);
    tick();
    check_eq("mc_c2_ctl", 32'(ctl()), 32'(CTL_MC));
    check_eq("mc_c2_busy", 32'(mc_busy_o), 32'd1);
    tick();
    branch_taken_i = 1'b1;
    #1 check_eq("mc_c3_ctl_br_ignored", 32'(ctl()), 32'(CTL_MC));
    check_eq("mc_c3_busy", 32'(mc_busy_o), 32'd1);
    tick();
    branch_taken_i = 1'b0;
    check_eq("mc_c3_flush_cnt", 32'(flush_cnt_o), 32'd0);
    check_eq("mc_rel_ctl", 32'(ctl()), 32'(CTL_RUN));
    check_eq("mc_rel_busy", 32'(mc_busy_o), 32'd1);
    tick();
    mc_start_i = 1'b0;
    #1 check_eq("mc_done_busy", 32'(mc_busy_o), 32'd0);
    check_eq("mc_stall_cnt", 32'(stall_cnt_o), 32'd3);
    check_eq("mc_done_ctl", 32'(ctl()), 32'(CTL_RUN));

    // Branch beats mc_start
    branch_taken_i = 1'b1; mc_start_i = 1'b1;
    #1 check_eq("br_mc_ctl", 32'(ctl()), 32'(CTL_BR));
    tick();
    idle_inputs();
    check_eq("br_mc_busy", 32'(mc_busy_o), 32'd0);
    check_eq("br_mc_flush_cnt", 32'(flush_cnt_o), 32'd1);

    // mc_start beats load-use
    mc_start_i = 1'b1;
    set_load_use(5'd5, 5'd6, 5'd5);
    #1 check_eq("mc_lu_ctl", 32'(ctl()), 32'(CTL_MC));
    tick();
    idle_inputs();
    check_eq("mc_lu_busy", 32'(mc_busy_o), 32'd1);
    repeat (3) tick();
    check_eq("mc_lu_drained", 32'(mc_busy_o), 32'd0);
    check_eq("mc_lu_stall_cnt", 32'(stall_cnt_o), 32'd6);

    // Saturation with 4-bit counters
    do_reset();
    set_load_use(5'd7, 5'd1, 5'd7);
    repeat (15) tick();
    check_eq("sat_stall_15", 32'(stall_cnt_o), 32'hF);
    repeat (5) tick();
    check_eq("sat_stall_20", 32'(stall_cnt_o), 32'hF);
    idle_inputs();
    branch_taken_i = 1'b1;
    repeat (20) tick();
    branch_taken_i = 1'b0;
    check_eq("sat_flush_20", 32'(flush_cnt_o), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
